// File: rtl/iword_encoder_pkg.sv
// Shared opcode constants, format classes and field positions for the
// instruction-word encoder and the fields decoder.
package iword_encoder_pkg;

  localparam int unsigned IWORD_W    = 39;
  localparam int unsigned ERR_W      = 2;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned IMM_LO_W   = 8;
  localparam int unsigned TAG_W      = 12;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;

  localparam int unsigned TAG_LSB = 27;
  localparam int unsigned OP_LSB  = 21;
  localparam int unsigned F0_LSB  = 16;
  localparam int unsigned F1_LSB  = 11;
  localparam int unsigned F2_LSB  = 6;
  localparam int unsigned IMM_LSB = 0;

  localparam int unsigned ERR_IMM_BIT = 0;
  localparam int unsigned ERR_ILL_BIT = 1;

  // Opcodes that force a field to zero
  localparam logic [OP_W-1:0] OP_BR_NOIMM  = 6'h23;
  localparam logic [OP_W-1:0] OP_JMP_NOREG = 6'h20;
  localparam logic [OP_W-1:0] OP_JMP_NOIMM = 6'h21;

  typedef enum logic [2:0] {
    FMT_RRR,
    FMT_RRI,
    FMT_RI,
    FMT_BR,
    FMT_JMP,
    FMT_SETB,
    FMT_STORE,
    FMT_ILLEGAL
  } fmt_e;

  typedef struct packed {
    logic [IWORD_W-1:0] iword;
    logic [ERR_W-1:0]   err;
  } fifo_entry_t;

  function automatic fmt_e op_format(input logic [OP_W-1:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h05, 6'h06, 6'h08, 6'h0A, 6'h0F,
      6'h17, 6'h18:                                   return FMT_RRR;
      6'h01, 6'h04, 6'h07, 6'h09, 6'h0B, 6'h0C, 6'h0E, 6'h10,
      6'h12, 6'h13, 6'h1A, 6'h1B, 6'h1C, 6'h30, 6'h32,
      6'h0D, 6'h11:                                   return FMT_RRI;
      6'h16, 6'h19:                                   return FMT_RI;
      6'h23, 6'h24, 6'h25:                            return FMT_BR;
      6'h20, 6'h21, 6'h22:                            return FMT_JMP;
      6'h14, 6'h15:                                   return FMT_SETB;
      6'h31, 6'h33:                                   return FMT_STORE;
      default:                                        return FMT_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/iword_encoder_fifo.sv
// Four-entry in-order queue of encoded words with occupancy count;
// flush empties it and drops any same-cycle push or pop.
module iword_fifo
  import iword_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  fifo_entry_t       wdata,
  output fifo_entry_t       head_c,
  output logic [CNT_W-1:0]  count
);

  fifo_entry_t             mem_q [FIFO_DEPTH];
  fifo_entry_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    push_ok, pop_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push && (count_q != CNT_W'(FIFO_DEPTH));
    pop_ok   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head reads as zero while the queue is empty
  assign head_c = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count  = count_q;

endmodule

// File: rtl/iword_encoder.sv
// Classifies a micro-op by opcode, packs it into a 39-bit instruction word
// with range/legality flags, and queues the result for the consumer.
module iword_encoder
  import iword_encoder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [REG_W-1:0]   in_wr,
  input  logic [REG_W-1:0]   in_rd0,
  input  logic [REG_W-1:0]   in_rd1,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IWORD_W-1:0] out_iword,
  output logic [ERR_W-1:0]   out_err,
  output logic [CNT_W-1:0]   out_count
);

  fmt_e               fmt;
  logic [IWORD_W-1:0] word;
  logic [ERR_W-1:0]   err;
  logic               imm_lo_used;
  fifo_entry_t        entry;
  fifo_entry_t        head;
  logic [CNT_W-1:0]   count;

  always_comb begin
    fmt         = op_format(in_op);
    word        = '0;
    err         = '0;
    imm_lo_used = 1'b0;
    word[TAG_LSB +: TAG_W] = in_tag;
    word[OP_LSB  +: OP_W]  = in_op;
    case (fmt)
      FMT_RRR: begin
        word[F0_LSB +: REG_W] = in_wr;
        word[F1_LSB +: REG_W] = in_rd0;
        word[F2_LSB +: REG_W] = in_rd1;
      end
      FMT_RRI: begin
        word[F0_LSB  +: REG_W]    = in_wr;
        word[F1_LSB  +: REG_W]    = in_rd0;
        word[IMM_LSB +: IMM_LO_W] = in_imm[IMM_LO_W-1:0];
        imm_lo_used               = 1'b1;
      end
      FMT_RI: begin
        word[F0_LSB  +: REG_W] = in_wr;
        word[IMM_LSB +: IMM_W] = in_imm;
      end
      FMT_BR: begin
        word[F0_LSB +: REG_W] = in_rd0;
        word[F1_LSB +: REG_W] = in_rd1;
        if (in_op != OP_BR_NOIMM) begin
          word[IMM_LSB +: IMM_LO_W] = in_imm[IMM_LO_W-1:0];
          imm_lo_used               = 1'b1;
        end
      end
      FMT_JMP: begin
        if (in_op != OP_JMP_NOREG) word[F0_LSB  +: REG_W] = in_rd0;
        if (in_op != OP_JMP_NOIMM) word[IMM_LSB +: IMM_W] = in_imm;
      end
      FMT_SETB: begin
        word[F0_LSB  +: REG_W]    = in_wr;
        word[F1_LSB  +: REG_W]    = in_rd1;
        word[IMM_LSB +: IMM_LO_W] = in_imm[IMM_LO_W-1:0];
        imm_lo_used               = 1'b1;
        err[ERR_ILL_BIT]          = (in_wr != in_rd0);
      end
      default: begin
        word[F0_LSB  +: REG_W]    = in_rd1;
        word[F1_LSB  +: REG_W]    = in_rd0;
        word[IMM_LSB +: IMM_LO_W] = in_imm[IMM_LO_W-1:0];
        imm_lo_used               = 1'b1;
        err[ERR_ILL_BIT]          = (fmt == FMT_ILLEGAL);
      end
    endcase
    // Byte immediates must be a faithful sign-extended 16-bit value
    err[ERR_IMM_BIT] = imm_lo_used &&
                       (in_imm[IMM_W-1:IMM_LO_W] != {IMM_LO_W{in_imm[IMM_LO_W-1]}});
    entry.iword = word;
    entry.err   = err;
  end

  iword_fifo u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .push   (in_valid && in_ready),
    .pop    (out_valid && out_ready),
    .wdata  (entry),
    .head_c (head),
    .count  (count)
  );

  assign in_ready  = (count < CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign out_iword = head.iword;
  assign out_err   = head.err;
  assign out_count = count;

endmodule

// File: tb/tb_iword_encoder.sv
// Directed bench for iword_encoder: queue-level reference model checked
// every cycle, plus hand-computed literal words.
module tb_iword_encoder;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_wr, in_rd0, in_rd1;
  logic [15:0] in_imm;
  logic [11:0] in_tag;
  logic [38:0] out_iword;
  logic [1:0]  out_err;
  logic [2:0]  out_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef struct { logic [38:0] w; logic [1:0] e; } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  iword_encoder dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_wr(in_wr), .in_rd0(in_rd0), .in_rd1(in_rd1),
    .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_iword(out_iword), .out_err(out_err), .out_count(out_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the opcode tables, built arithmetically
  function automatic ent_t model_encode(input int op, wr, rd0, rd1, imm, tag);
    ent_t   r;
    longint v;
    bit     byte_imm = 0;
    bit     ill = 0;
    int     lo, s;
    v = longint'(tag) * (64'd1 << 27) + longint'(op) * (64'd1 << 21);
    if (op inside {'h00,'h02,'h03,'h05,'h06,'h08,'h0A,'h0F,'h17,'h18})
      v += wr * 65536 + rd0 * 2048 + rd1 * 64;
    else if (op inside {'h01,'h04,'h07,'h09,'h0B,'h0C,'h0E,'h10,'h12,'h13,
                        'h1A,'h1B,'h1C,'h30,'h32,'h0D,'h11}) begin
      v += wr * 65536 + rd0 * 2048 + imm % 256; byte_imm = 1;
    end else if (op inside {'h16,'h19})
      v += wr * 65536 + imm;
    else if (op inside {'h23,'h24,'h25}) begin
      v += rd0 * 65536 + rd1 * 2048;
      if (op != 'h23) begin v += imm % 256; byte_imm = 1; end
    end else if (op inside {'h20,'h21,'h22}) begin
      if (op != 'h20) v += rd0 * 65536;
      if (op != 'h21) v += imm;
    end else if (op inside {'h14,'h15}) begin
      v += wr * 65536 + rd1 * 2048 + imm % 256; byte_imm = 1;
      ill = (wr != rd0);
    end else begin
      v += rd1 * 65536 + rd0 * 2048 + imm % 256; byte_imm = 1;
      ill = !(op inside {'h31,'h33});
    end
    lo = imm % 256;
    s  = (lo >= 128) ? lo - 256 : lo;
    r.w = v[38:0];
    r.e = {ill, byte_imm && ((s & 'hFFFF) != imm)};
    return r;
  endfunction

  // Queue-level reference model, advanced on each rising edge
  always @(posedge clk) begin
    bit do_pop, do_push;
    if (reset || flush) q.delete();
    else begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < 4);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model_encode(in_op, in_wr, in_rd0, in_rd1, in_imm, in_tag));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",     64'(out_count), 64'(q.size()));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready",  64'(in_ready),  64'(q.size() < 4));
      chk("out_iword", 64'(out_iword), (q.size() > 0) ? 64'(q[0].w) : 64'd0);
      chk("out_err",   64'(out_err),   (q.size() > 0) ? 64'(q[0].e) : 64'd0);
    end
  end

  task automatic set_req(input int op, wr, rd0, rd1, imm, tag);
    in_op = 6'(op); in_wr = 5'(wr); in_rd0 = 5'(rd0); in_rd1 = 5'(rd1);
    in_imm = 16'(imm); in_tag = 12'(tag); in_valid = 1'b1;
  endtask

  // Hold a request until accepted; leaves in_valid high, returns at edge+1
  task automatic push_req(input int op, wr, rd0, rd1, imm, tag);
    bit acc;
    bit done = 0;
    set_req(op, wr, rd0, rd1, imm, tag);
    for (int i = 0; i < 40 && !done; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
      done = acc;
    end
    if (!done) begin n_cmp++; n_bad++; $display("FAIL push_timeout: op 0x%0h never accepted", op); end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && out_count != 0; i++) begin @(posedge clk); #1; end
    chk("drain_empty", 64'(out_count), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0); in_valid = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready),  64'd1);
    chk("rst_iword", 64'(out_iword), 64'd0);
    chk("rst_err",   64'(out_err),   64'd0);

    // Model sanity against hand-computed words
    chk("model_rrr", 64'(model_encode('h02, 3, 5, 7, 0, 0).w), 64'h004329C0);
    chk("model_jmp", 64'(model_encode('h21, 0, 4, 0, 'h1234, 0).w), 64'h04240000);
    chk("model_ill", 64'(model_encode('h3F, 0, 0, 0, 0, 0).e), 64'd2);

    push_req('h02, 3, 5, 7, 0, 0); in_valid = 1'b0;
    chk("rrr_word", 64'(out_iword), 64'h004329C0);
    chk("rrr_err",  64'(out_err), 64'd0);
    drain();
    push_req('h01, 1, 2, 0, 'hFFFE, 0); in_valid = 1'b0;
    chk("rri_word", 64'(out_iword), 64'h002110FE);
    chk("rri_err",  64'(out_err), 64'd0);
    drain();
    push_req('h01, 1, 2, 0, 'h0080, 0); in_valid = 1'b0;
    chk("rri_range_err", 64'(out_err), 64'd1);
    drain();
    push_req('h21, 0, 4, 0, 'h1234, 0); in_valid = 1'b0;
    chk("jmp21_word", 64'(out_iword), 64'h04240000);
    chk("jmp21_err",  64'(out_err), 64'd0);
    drain();
    push_req('h20, 0, 9, 0, 'h0055, 0); in_valid = 1'b0;
    chk("jmp20_word", 64'(out_iword), 64'h04000055);
    drain();
    push_req('h3F, 0, 1, 2, 5, 0); in_valid = 1'b0;
    chk("ill_word", 64'(out_iword), 64'h07E20805);
    chk("ill_err",  64'(out_err), 64'd2);
    drain();
    push_req('h14, 2, 3, 4, 'h10, 0); in_valid = 1'b0;
    chk("setb_word", 64'(out_iword), 64'h02822010);
    chk("setb_err",  64'(out_err), 64'd2);
    drain();
    push_req('h23, 1, 2, 3, 'h1280, 0); in_valid = 1'b0;
    chk("br23_forced_err", 64'(out_err), 64'd0);
    drain();

    // Full queue: four accepted, fifth held, then pop+push keeps count at 4
    for (int i = 1; i <= 4; i++) push_req('h02, i, i, i, 0, i);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(out_count), 64'd4);
    set_req('h02, 5, 5, 5, 0, 5);
    idle(0); in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("held_count", 64'(out_count), 64'd4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("poppush_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("poppush_count", 64'(out_count), 64'd4);
    chk("poppush_head_tag", 64'(out_iword[38:27]), 64'd2);
    drain();

    // Flush with three queued and a simultaneous push
    for (int i = 1; i <= 3; i++) push_req('h16, i, 0, 0, 'h100 * i, 'h10 + i);
    set_req('h16, 7, 0, 0, 'h777, 'hEE); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 64'(out_count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    push_req('h19, 4, 0, 0, 'hBEEF, 'h0A1); in_valid = 1'b0;
    chk("post_flush_tag", 64'(out_iword[38:27]), 64'h0A1);
    drain();

    // Reset mid-stream with a simultaneous push and flush
    for (int i = 1; i <= 3; i++) push_req('h24, 0, i, i, i, 'h20 + i);
    set_req('h24, 0, 6, 6, 6, 'hDD); reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("reset_count", 64'(out_count), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    idle(2);

    // Sweep every opcode with varied fields and intermittent draining
    for (int op = 0; op < 64; op++) begin
      out_ready = (op % 3) != 0;
      push_req(op, op % 32, (op * 7) % 32, (op * 13) % 32,
               (op % 4 == 0) ? 'hFF80 + op : (op * 'h135) % 'h10000, op * 61);
    end
    in_valid = 1'b0;
    drain();
    idle(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iword_encoder.md
IWORD_ENCODER -- requirements
Module: iword_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port flush, input, 1 bit: synchronous discard of all queued words.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-005 SHALL have ports in_op (input, 6), in_wr (5), in_rd0 (5), in_rd1 (5), in_imm (16), in_tag (12): micro-op fields.
REQ-006 SHALL have ports out_valid (output, 1) and out_ready (input, 1): word handshake.
REQ-007 SHALL have ports out_iword (output, 39), out_err (output, 2: bit0 imm range, bit1 illegal op/operand), out_count (output, 3: queued words).

Function
REQ-008 SHALL accept a request on any edge where in_valid and in_ready are both 1.
REQ-009 SHALL assert in_ready exactly when out_count < 4; no full-queue bypass.
REQ-010 SHALL pack iword[38:27]=in_tag and iword[26:21]=in_op; unused bits SHALL be 0.
REQ-011 RRR ops (00,02,03,05,06,08,0A,0F,17,18) SHALL pack [20:16]=wr, [15:11]=rd0, [10:6]=rd1.
REQ-012 RRI ops (01,04,07,09,0B,0C,0E,10,12,13,1A,1B,1C,30,32) and special ops (0D,11) SHALL pack [20:16]=wr, [15:11]=rd0, [7:0]=imm[7:0].
REQ-013 RI ops (16,19) SHALL pack [20:16]=wr, [15:0]=imm.
REQ-014 Branch ops (23,24,25) SHALL pack [20:16]=rd0, [15:11]=rd1, [7:0]=imm[7:0]; op 23 SHALL force [7:0]=0.
REQ-015 Jump ops (20,21,22) SHALL pack [20:16]=rd0 and [15:0]=imm; op 20 SHALL force [20:16]=0 and op 21 SHALL force [15:0]=0.
REQ-016 Setbit ops (14,15) SHALL pack [20:16]=wr, [15:11]=rd1, [7:0]=imm[7:0]; wr≠rd0 SHALL set err bit1.
REQ-017 Store/out (31,33) and every unlisted op SHALL pack [20:16]=rd1, [15:11]=rd0, [7:0]=imm[7:0]; unlisted ops SHALL set err bit1.
REQ-018 Any format placing imm[7:0] SHALL set err bit0 when imm[15:8] is not the sign extension of imm[7]; forced-zero fields SHALL NOT flag.
REQ-019 The encoded word and err bits SHALL be written to a 4-entry in-order FIFO at the accepting edge.
REQ-020 out_valid SHALL be 1 exactly when out_count > 0; out_iword/out_err SHALL show the head entry, stable until popped.
REQ-021 The head SHALL pop on an edge with out_valid and out_ready both 1.
REQ-022 First-word latency SHALL be one cycle: accepted at edge N, visible from edge N onward and poppable at edge N+1.
REQ-023 Simultaneous push and pop SHALL leave out_count unchanged; pointers SHALL wrap modulo 4.
REQ-024 flush SHALL set out_count to 0 at the next edge and SHALL drop any push or pop in that cycle.
REQ-025 out_iword and out_err SHALL read 0 whenever out_valid is 0.

Reset
REQ-026 On reset: out_count=0, out_valid=0, in_ready=1 (from the cycle after), out_iword=0, out_err=0, pointers=0.
REQ-027 Reset SHALL take priority over flush, push and pop; a reset mid-stream SHALL lose all queued words.

Structure
REQ-028 Opcode constants, format-class codes and field bit positions SHALL live in a shared package, also used by fields_decoder.
REQ-029 The queue SHALL be one sub-module, iword_fifo (39+2 bits wide, depth 4, count output); classification and packing stay in iword_encoder.

Verification
REQ-030 RRR: op=02, wr=3, rd0=5, rd1=7, tag=0 -> out_iword=0x004329C0, out_err=0 one cycle later.
REQ-031 RRI: op=01, wr=1, rd0=2, imm=0xFFFE -> 0x002110FE with err=0; imm=0x0080 -> err=01.
REQ-032 Jump: op=21, rd0=4, imm=0x1234 -> 0x04240000 with err=0; op=20 gives [20:16]=0.
REQ-033 Full queue: out_ready=0, five back-to-back requests -> in_ready low after the 4th, 5th held; one pop then push -> count stays 4, order preserved.
REQ-034 Illegal/setbit: op=3F -> err=10 in store format; op=14 with wr=2, rd0=3 -> err bit1 set.
REQ-035 Flush/reset with 3 queued words and a simultaneous push -> count=0, out_valid=0 next cycle, the pushed word never emerges.
